// File: rtl/relin_pkg.sv
// Shared types and default sizes for the relinearization-key stream scheduler.
package relin_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_RDY = 2'd1,
    STREAM   = 2'd2,
    DONE     = 2'd3
  } state_t;

  typedef enum logic {
    PHASE_C0 = 1'b0,
    PHASE_C1 = 1'b1
  } phase_t;

  localparam int unsigned DEFAULT_TILE_WIDTH = 8;
  localparam int unsigned DEFAULT_KEY_LENGTH = 512;
  localparam int unsigned DEFAULT_ITER_WIDTH = 8;

endpackage

// File: rtl/relin_tile_tracker.sv
// Tile counter, last-tile detect and loader address/protocol checking.
module relin_tile_tracker #(
  parameter int unsigned TILE_WIDTH = 8,
  parameter int unsigned KEY_LENGTH = 512,
  localparam int unsigned NUM_TILES = KEY_LENGTH / TILE_WIDTH,
  localparam int unsigned CNT_W     = $clog2(NUM_TILES),
  localparam int unsigned ADDR_W    = $clog2(KEY_LENGTH) + 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              accept,
  input  logic              clear_err,
  input  logic [ADDR_W-1:0] loader_address,
  input  logic              loader_request_new_input,
  output logic [CNT_W-1:0]  tile_cnt,
  output logic              at_last,
  output logic              addr_err
);

  logic [ADDR_W-1:0] expected_addr;
  logic              err_hit;

  assign at_last       = (tile_cnt == CNT_W'(NUM_TILES - 1));
  assign expected_addr = ADDR_W'(tile_cnt) * ADDR_W'(TILE_WIDTH);
  // Wrong address, or the loader claiming its last tile before we reach it.
  assign err_hit = accept & ((loader_address != expected_addr) |
                             (loader_request_new_input & ~at_last));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tile_cnt <= '0;
    end else if (clear) begin
      tile_cnt <= '0;
    end else if (accept) begin
      tile_cnt <= at_last ? '0 : tile_cnt + CNT_W'(1);
    end
  end

  // Sticky until the next accepted job start.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      addr_err <= 1'b0;
    end else if (clear_err) begin
      addr_err <= 1'b0;
    end else if (err_hit) begin
      addr_err <= 1'b1;
    end
  end

endmodule

// File: rtl/relin_key_sched.sv
// Relinearization-key streaming scheduler: per iteration streams C0 then C1 tiles.
// Optional RELIN_KEY_SCHED_PERF_EN adds saturating stream/stall cycle counters.
module relin_key_sched
  import relin_pkg::*;
#(
  parameter int unsigned RELIN_KEY_TILE_WIDTH = DEFAULT_TILE_WIDTH,
  parameter int unsigned RELIN_KEY_LENGTH     = DEFAULT_KEY_LENGTH,
  parameter int unsigned ITER_WIDTH           = DEFAULT_ITER_WIDTH
) (
  input  logic                                                   clk,
  input  logic                                                   reset,
  input  logic                                                   start,
  input  logic [ITER_WIDTH-1:0]                                  job_iters,
  input  logic                                                   abort,
  input  logic                                                   mult_ready,
  input  logic                                                   loader_valid_address,
  input  logic [$clog2(RELIN_KEY_LENGTH):0]                      loader_address,
  input  logic                                                   loader_request_new_input,
  output logic                                                   loader_request,
  output logic                                                   loader_c1_or_c0,
  output logic                                                   tile_valid,
  output logic [$clog2(RELIN_KEY_LENGTH/RELIN_KEY_TILE_WIDTH)-1:0] tile_index,
  output logic                                                   tile_phase,
  output logic                                                   tile_last,
  output logic                                                   busy,
  output logic                                                   done,
  output logic                                                   aborted,
  output logic                                                   addr_err
`ifdef RELIN_KEY_SCHED_PERF_EN
  ,
  output logic [31:0]                                            perf_busy_cycles,
  output logic [31:0]                                            perf_stall_cycles
`endif
);

  localparam int unsigned NUM_TILES = RELIN_KEY_LENGTH / RELIN_KEY_TILE_WIDTH;
  localparam int unsigned CNT_W     = $clog2(NUM_TILES);

  state_t                state, state_nxt;
  phase_t                phase;
  logic [ITER_WIDTH-1:0] iters_q;
  logic [ITER_WIDTH-1:0] iter_cnt;
  logic                  zero_done;
  logic                  aborted_q;
  logic [CNT_W-1:0]      tile_cnt;
  logic                  at_last;
  logic                  in_stream;
  logic                  accept;
  logic                  last_iter;
  logic                  c1_end;
  logic                  start_ok;
  logic                  start_zero;
  logic                  abort_hit;

  assign in_stream  = (state == STREAM);
  assign accept     = in_stream & loader_valid_address;
  assign last_iter  = (iter_cnt == iters_q - ITER_WIDTH'(1));
  assign c1_end     = accept & at_last & (phase == PHASE_C1);
  assign start_ok   = (state == IDLE) & start & (job_iters != '0);
  assign start_zero = (state == IDLE) & start & (job_iters == '0);
  assign abort_hit  = (state != IDLE) & abort;

  relin_tile_tracker #(
    .TILE_WIDTH (RELIN_KEY_TILE_WIDTH),
    .KEY_LENGTH (RELIN_KEY_LENGTH)
  ) u_tracker (
    .clk                      (clk),
    .reset                    (reset),
    .clear                    (~in_stream),
    .accept                   (accept),
    .clear_err                (start_ok),
    .loader_address           (loader_address),
    .loader_request_new_input (loader_request_new_input),
    .tile_cnt                 (tile_cnt),
    .at_last                  (at_last),
    .addr_err                 (addr_err)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (start_ok) state_nxt = WAIT_RDY;
      end
      WAIT_RDY: begin
        if (abort)           state_nxt = IDLE;
        else if (mult_ready) state_nxt = STREAM;
      end
      STREAM: begin
        if (abort)                  state_nxt = IDLE;
        else if (c1_end && last_iter) state_nxt = DONE;
        else if (c1_end && !mult_ready) state_nxt = WAIT_RDY;
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Request falls in the final C1 tile cycle when the loader must not wrap.
  always_comb begin
    loader_request = 1'b0;
    tile_valid     = 1'b0;
    tile_last      = 1'b0;
    busy           = (state != IDLE);
    done           = zero_done;
    unique case (state)
      STREAM: begin
        loader_request = ~abort & ~(loader_valid_address & at_last & (phase == PHASE_C1) &
                                    (last_iter | ~mult_ready));
        tile_valid     = loader_valid_address;
        tile_last      = loader_valid_address & at_last & (phase == PHASE_C1) & last_iter;
      end
      DONE:    done = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      phase     <= PHASE_C0;
      iters_q   <= '0;
      iter_cnt  <= '0;
      zero_done <= 1'b0;
      aborted_q <= 1'b0;
    end else begin
      zero_done <= start_zero;
      aborted_q <= abort_hit;
      if (start_ok) begin
        iters_q  <= job_iters;
        iter_cnt <= '0;
        phase    <= PHASE_C0;
      end else if (abort_hit) begin
        phase <= PHASE_C0;
      end else if (accept && at_last) begin
        if (phase == PHASE_C0) begin
          phase <= PHASE_C1;
        end else begin
          phase    <= PHASE_C0;
          iter_cnt <= iter_cnt + ITER_WIDTH'(1);
        end
      end
    end
  end

  assign loader_c1_or_c0 = phase;
  assign tile_phase      = phase;
  assign tile_index      = tile_cnt;
  assign aborted         = aborted_q;

`ifdef RELIN_KEY_SCHED_PERF_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      perf_busy_cycles  <= '0;
      perf_stall_cycles <= '0;
    end else if (start_ok) begin
      perf_busy_cycles  <= '0;
      perf_stall_cycles <= '0;
    end else begin
      if (state == STREAM && perf_busy_cycles != '1)
        perf_busy_cycles <= perf_busy_cycles + 32'd1;
      if (state == WAIT_RDY && perf_stall_cycles != '1)
        perf_stall_cycles <= perf_stall_cycles + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_relin_key_sched.sv
// Bench for relin_key_sched: loader model plus queue-based expected tile stream.
module tb_relin_key_sched;

  localparam int NT = 64;
  localparam int TW = 8;
  localparam int AW = 10;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [7:0]  job_iters;
  logic        abort;
  logic        mult_ready;
  logic        loader_valid_address;
  logic [AW-1:0] loader_address;
  logic        loader_request_new_input;
  logic        loader_request;
  logic        loader_c1_or_c0;
  logic        tile_valid;
  logic [5:0]  tile_index;
  logic        tile_phase;
  logic        tile_last;
  logic        busy;
  logic        done;
  logic        aborted;
  logic        addr_err;
`ifdef RELIN_KEY_SCHED_PERF_EN
  logic [31:0] perf_busy_cycles;
  logic [31:0] perf_stall_cycles;
`endif

  relin_key_sched dut (
    .clk                      (clk),
    .reset                    (reset),
    .start                    (start),
    .job_iters                (job_iters),
    .abort                    (abort),
    .mult_ready               (mult_ready),
    .loader_valid_address     (loader_valid_address),
    .loader_address           (loader_address),
    .loader_request_new_input (loader_request_new_input),
    .loader_request           (loader_request),
    .loader_c1_or_c0          (loader_c1_or_c0),
    .tile_valid               (tile_valid),
    .tile_index               (tile_index),
    .tile_phase               (tile_phase),
    .tile_last                (tile_last),
    .busy                     (busy),
    .done                     (done),
    .aborted                  (aborted),
    .addr_err                 (addr_err)
`ifdef RELIN_KEY_SCHED_PERF_EN
    ,
    .perf_busy_cycles         (perf_busy_cycles),
    .perf_stall_cycles        (perf_stall_cycles)
`endif
  );

  always #5 clk = ~clk;

  int checks;
  int errors;

  // Loader model: starts a tile the cycle after request, wraps after the last tile.
  logic ld_active;
  int   ld_tile;
  int   fault_tile;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      ld_active <= 1'b0;
      ld_tile   <= 0;
    end else begin
      ld_active <= loader_request;
      if (loader_request && ld_active) ld_tile <= (ld_tile == NT - 1) ? 0 : ld_tile + 1;
      else                             ld_tile <= 0;
    end
  end

  assign loader_valid_address     = ld_active;
  assign loader_address           = (ld_tile == fault_tile) ? AW'(48) : AW'(ld_tile * TW);
  assign loader_request_new_input = ld_active && (ld_tile == NT - 1);

  typedef struct {
    bit ph;
    int idx;
    bit last;
  } exp_t;

  exp_t exp_q[$];
  exp_t e;
  int   done_cnt;
  int   abort_cnt;

  // Scoreboard: every presented tile must match the next expected (phase, index, last).
  always @(negedge clk) begin
    if (!reset) begin
      if (done === 1'b1) done_cnt++;
      if (aborted === 1'b1) abort_cnt++;
      if (tile_valid === 1'b1) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL tile_stream: unexpected tile idx=%0d phase=%0b", tile_index, tile_phase);
        end else begin
          e = exp_q.pop_front();
          if ({tile_phase, loader_c1_or_c0, tile_index, tile_last} !==
              {e.ph, e.ph, 6'(e.idx), e.last}) begin
            errors++;
            $display("FAIL tile_stream: got phase=%0b sel=%0b idx=%0d last=%0b, need phase=%0b idx=%0d last=%0b",
                     tile_phase, loader_c1_or_c0, tile_index, tile_last, e.ph, e.idx, e.last);
          end
        end
      end
    end
  end

  task automatic tick;
    @(negedge clk);
    #1;
  endtask

  task automatic push_job(input int n);
    for (int i = 0; i < n; i++)
      for (int p = 0; p < 2; p++)
        for (int t = 0; t < NT; t++)
          exp_q.push_back('{ph: bit'(p), idx: t, last: (p == 1 && t == NT - 1 && i == n - 1)});
  endtask

  task automatic test_reset;
    reset = 1'b1; start = 1'b0; job_iters = '0; abort = 1'b0; mult_ready = 1'b0;
    fault_tile = -1;
    repeat (2) tick;
    checks++;
    if ({loader_request, loader_c1_or_c0, tile_valid, tile_last, busy, done, aborted, addr_err} !== 8'h00) begin
      errors++;
      $display("FAIL reset_ctrl: got %b, need 00000000",
               {loader_request, loader_c1_or_c0, tile_valid, tile_last, busy, done, aborted, addr_err});
    end
    checks++;
    if (tile_index !== 6'd0 || tile_phase !== 1'b0) begin
      errors++;
      $display("FAIL reset_tile: idx=%0d phase=%b, need 0/0", tile_index, tile_phase);
    end
`ifdef RELIN_KEY_SCHED_PERF_EN
    checks++;
    if (perf_busy_cycles !== 32'd0 || perf_stall_cycles !== 32'd0) begin
      errors++;
      $display("FAIL reset_perf: busy=%0d stall=%0d, need 0/0", perf_busy_cycles, perf_stall_cycles);
    end
`endif
    reset = 1'b0;
    tick;
  endtask

  task automatic test_single;
    int k, first_k, last_k, nvalid, tl_k, done_k, d0;
    first_k = -1; last_k = -1; nvalid = 0; tl_k = -1; done_k = -1; d0 = done_cnt;
    push_job(1);
    mult_ready = 1'b1; job_iters = 8'd1; start = 1'b1;
    tick;
    start = 1'b0;
    k = 1;
    while (done_k < 0 && k < 400) begin
      if (k == 1) begin
        checks++;
        if (!(busy === 1'b1 && loader_request === 1'b0)) begin
          errors++;
          $display("FAIL single_wait: busy=%b request=%b, need 1/0", busy, loader_request);
        end
      end
      if (k == 2) begin
        checks++;
        if (!(loader_request === 1'b1 && tile_valid === 1'b0)) begin
          errors++;
          $display("FAIL single_req: request=%b valid=%b, need 1/0", loader_request, tile_valid);
        end
      end
      if (tile_valid === 1'b1) begin
        if (first_k < 0) first_k = k;
        last_k = k;
        nvalid++;
      end
      if (tile_last === 1'b1) begin
        tl_k = k;
        checks++;
        if (loader_request !== 1'b0) begin
          errors++;
          $display("FAIL single_last_req: request=%b, need 0", loader_request);
        end
      end
      if (done === 1'b1) done_k = k;
      else begin tick; k++; end
    end
    checks++;
    if (done_k < 0) begin errors++; $display("FAIL single_timeout: no done after %0d cycles", k); end
    checks++;
    if (first_k != 3) begin errors++; $display("FAIL single_first: first tile cycle %0d, need 3", first_k); end
    checks++;
    if (nvalid != 2 * NT || last_k - first_k != 2 * NT - 1) begin
      errors++;
      $display("FAIL single_contig: %0d tiles over %0d cycles, need 128/128", nvalid, last_k - first_k + 1);
    end
    checks++;
    if (tl_k != 130 || done_k != tl_k + 1) begin
      errors++;
      $display("FAIL single_done: tile_last at %0d done at %0d, need 130/131", tl_k, done_k);
    end
`ifdef RELIN_KEY_SCHED_PERF_EN
    checks++;
    if (perf_busy_cycles !== 32'd129 || perf_stall_cycles !== 32'd1) begin
      errors++;
      $display("FAIL single_perf: busy=%0d stall=%0d, need 129/1", perf_busy_cycles, perf_stall_cycles);
    end
`endif
    tick;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || loader_c1_or_c0 !== 1'b0 || exp_q.size() != 0 || done_cnt - d0 != 1) begin
      errors++;
      $display("FAIL single_end: busy=%b done=%b sel=%b left=%0d dones=%0d, need 0/0/0/0/1",
               busy, done, loader_c1_or_c0, exp_q.size(), done_cnt - d0);
    end
  endtask

  // Three iterations back to back; a start pulse mid-job must be ignored.
  task automatic test_back_to_back;
    int k, first_k, last_k, nvalid, d0;
    bit fin;
    first_k = -1; last_k = -1; nvalid = 0; d0 = done_cnt; fin = 0;
    push_job(3);
    mult_ready = 1'b1; job_iters = 8'd3; start = 1'b1;
    tick;
    start = 1'b0;
    k = 1;
    while (!fin && k < 1000) begin
      if (tile_valid === 1'b1) begin
        if (first_k < 0) first_k = k;
        last_k = k;
        nvalid++;
      end
      start = (k == 50);
      job_iters = (k == 50) ? 8'd1 : 8'd3;
      if (done === 1'b1) fin = 1;
      else begin tick; k++; end
    end
    start = 1'b0;
    repeat (3) tick;
    checks++;
    if (!fin) begin errors++; $display("FAIL b2b_timeout: no done after %0d cycles", k); end
    checks++;
    if (nvalid != 6 * NT || last_k - first_k != 6 * NT - 1) begin
      errors++;
      $display("FAIL b2b_contig: %0d tiles over %0d cycles, need 384/384", nvalid, last_k - first_k + 1);
    end
    checks++;
    if (done_cnt - d0 != 1 || exp_q.size() != 0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL b2b_end: dones=%0d left=%0d busy=%b, need 1/0/0", done_cnt - d0, exp_q.size(), busy);
    end
  endtask

  task automatic test_stall;
    int k, n, t63_k, rel_k, stall_bad, d0;
    bit fin;
    k = 1; n = 0; t63_k = -1; rel_k = -100; stall_bad = 0; d0 = done_cnt; fin = 0;
    push_job(2);
    mult_ready = 1'b1; job_iters = 8'd2; start = 1'b1;
    tick;
    start = 1'b0;
    while (!fin && k < 1000) begin
      if (tile_valid === 1'b1) begin
        n++;
        if (n == NT + 41) mult_ready = 1'b0;
        if (n == 2 * NT) begin
          checks++;
          if (loader_request !== 1'b0) begin
            errors++;
            $display("FAIL stall_req: request=%b at C1 tile 63, need 0", loader_request);
          end
          t63_k = k;
          rel_k = k + 10;
        end
        if (n == 2 * NT + 1) begin
          checks++;
          if (k != rel_k + 2 || tile_index !== 6'd0 || tile_phase !== 1'b0) begin
            errors++;
            $display("FAIL stall_resume: cycle %0d idx=%0d phase=%b, need %0d/0/0", k, tile_index, tile_phase, rel_k + 2);
          end
        end
      end
      if (t63_k > 0 && k > t63_k && k <= rel_k)
        if (!(busy === 1'b1 && loader_request === 1'b0 && tile_valid === 1'b0)) stall_bad++;
      if (t63_k > 0 && k == rel_k + 1) begin
        checks++;
        if (!(loader_request === 1'b1 && tile_valid === 1'b0)) begin
          errors++;
          $display("FAIL stall_restart: request=%b valid=%b, need 1/0", loader_request, tile_valid);
        end
      end
      if (t63_k > 0 && k == rel_k) mult_ready = 1'b1;
      if (done === 1'b1) fin = 1;
      else begin tick; k++; end
    end
    tick;
    checks++;
    if (stall_bad != 0 || t63_k < 0) begin
      errors++;
      $display("FAIL stall_wait: %0d bad wait cycles, t63 at %0d, need 0 and seen", stall_bad, t63_k);
    end
    checks++;
    if (!fin || done_cnt - d0 != 1 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL stall_end: fin=%0b dones=%0d left=%0d, need 1/1/0", fin, done_cnt - d0, exp_q.size());
    end
  endtask

  task automatic test_random;
    int k, n, iters, d0;
    bit fin;
    for (int r = 0; r < 4; r++) begin
      iters = int'($urandom_range(1, 3));
      k = 1; n = 0; d0 = done_cnt; fin = 0;
      push_job(iters);
      mult_ready = 1'b1; job_iters = 8'(iters); start = 1'b1;
      tick;
      start = 1'b0;
      while (!fin && k < 4000) begin
        if (tile_valid === 1'b1) n++;
        mult_ready = ($urandom_range(0, 3) != 0);
        if (done === 1'b1) fin = 1;
        else begin tick; k++; end
      end
      mult_ready = 1'b1;
      tick;
      checks++;
      if (!fin || n != 2 * NT * iters || done_cnt - d0 != 1 || exp_q.size() != 0 || addr_err !== 1'b0) begin
        errors++;
        $display("FAIL random_job: iters=%0d fin=%0b tiles=%0d dones=%0d left=%0d err=%b, need 1/%0d/1/0/0",
                 iters, fin, n, done_cnt - d0, exp_q.size(), addr_err, 2 * NT * iters);
      end
      exp_q.delete();
    end
  endtask

  task automatic test_addr_err;
    int k;
    bit fin;
    fault_tile = 5;
    push_job(1);
    mult_ready = 1'b1; job_iters = 8'd1; start = 1'b1;
    tick;
    start = 1'b0;
    k = 1; fin = 0;
    while (!fin && k < 400) begin
      if (tile_valid === 1'b1 && tile_index === 6'd5 && tile_phase === 1'b0) begin
        checks++;
        if (addr_err !== 1'b0) begin errors++; $display("FAIL err_early: addr_err=%b before bad tile, need 0", addr_err); end
      end
      if (done === 1'b1) fin = 1;
      else begin tick; k++; end
    end
    repeat (3) tick;
    checks++;
    if (!fin || addr_err !== 1'b1) begin
      errors++;
      $display("FAIL err_sticky: fin=%0b addr_err=%b, need 1/1", fin, addr_err);
    end
    fault_tile = -1;
    exp_q.delete();
    push_job(1);
    start = 1'b1;
    tick;
    start = 1'b0;
    checks++;
    if (addr_err !== 1'b0) begin errors++; $display("FAIL err_clear: addr_err=%b after start, need 0", addr_err); end
    k = 1; fin = 0;
    while (!fin && k < 400) begin
      if (done === 1'b1) fin = 1;
      else begin tick; k++; end
    end
    tick;
    checks++;
    if (!fin || addr_err !== 1'b0) begin
      errors++;
      $display("FAIL err_clean: fin=%0b addr_err=%b, need 1/0", fin, addr_err);
    end
  endtask

  task automatic test_abort;
    int k, d0, a0;
    bit hit;
    push_job(2);
    mult_ready = 1'b1; job_iters = 8'd2; start = 1'b1;
    tick;
    start = 1'b0;
    k = 1; hit = 0;
    while (!hit && k < 200) begin
      if (tile_valid === 1'b1 && tile_index === 6'd20 && tile_phase === 1'b0) hit = 1;
      else begin tick; k++; end
    end
    checks++;
    if (!hit) begin errors++; $display("FAIL abort_timeout: C0 tile 20 not seen in %0d cycles", k); end
    d0 = done_cnt;
    abort = 1'b1;
    #1;
    checks++;
    if (loader_request !== 1'b0) begin errors++; $display("FAIL abort_req: request=%b, need 0", loader_request); end
    tick;
    abort = 1'b0;
    exp_q.delete();
    checks++;
    if ({aborted, done, busy, loader_c1_or_c0} !== 4'b1000) begin
      errors++;
      $display("FAIL abort_pulse: aborted/done/busy/sel=%b, need 1000", {aborted, done, busy, loader_c1_or_c0});
    end
    a0 = abort_cnt;
    repeat (3) tick;
    checks++;
    if (aborted !== 1'b0 || tile_valid !== 1'b0 || done_cnt != d0 || abort_cnt != a0) begin
      errors++;
      $display("FAIL abort_after: aborted=%b valid=%b dones=%0d extra_aborts=%0d, need 0/0/0/0",
               aborted, tile_valid, done_cnt - d0, abort_cnt - a0);
    end
    // Zero-iteration job completes immediately without becoming busy.
    job_iters = 8'd0; start = 1'b1;
    tick;
    start = 1'b0;
    checks++;
    if (done !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL zero_iter: done=%b busy=%b, need 1/0", done, busy);
    end
    tick;
    checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL zero_iter_after: done=%b busy=%b, need 0/0", done, busy);
    end
    // Start and abort together while idle: start wins; then abort from WAIT_RDY.
    mult_ready = 1'b0; job_iters = 8'd1; start = 1'b1; abort = 1'b1;
    tick;
    start = 1'b0; abort = 1'b0;
    checks++;
    if (busy !== 1'b1 || aborted !== 1'b0) begin
      errors++;
      $display("FAIL start_abort_idle: busy=%b aborted=%b, need 1/0", busy, aborted);
    end
    abort = 1'b1;
    tick;
    abort = 1'b0;
    checks++;
    if (busy !== 1'b0 || aborted !== 1'b1 || done !== 1'b0) begin
      errors++;
      $display("FAIL abort_wait: busy=%b aborted=%b done=%b, need 0/1/0", busy, aborted, done);
    end
    mult_ready = 1'b1;
    tick;
  endtask

  task automatic test_reset_mid;
    int k;
    bit hit;
    push_job(1);
    mult_ready = 1'b1; job_iters = 8'd1; start = 1'b1;
    tick;
    start = 1'b0;
    k = 1; hit = 0;
    while (!hit && k < 200) begin
      if (tile_valid === 1'b1 && tile_index === 6'd30) hit = 1;
      else begin tick; k++; end
    end
    reset = 1'b1;
    #1;
    checks++;
    if (!hit || {loader_request, loader_c1_or_c0, tile_valid, tile_last, busy, done, aborted, addr_err} !== 8'h00 ||
        tile_index !== 6'd0) begin
      errors++;
      $display("FAIL reset_mid: hit=%0b outs=%b idx=%0d, need 1/00000000/0", hit,
               {loader_request, loader_c1_or_c0, tile_valid, tile_last, busy, done, aborted, addr_err}, tile_index);
    end
    tick;
    reset = 1'b0;
    exp_q.delete();
    tick;
    checks++;
    if (busy !== 1'b0 || loader_request !== 1'b0) begin
      errors++;
      $display("FAIL reset_release: busy=%b request=%b, need 0/0", busy, loader_request);
    end
  endtask

  initial begin
    checks = 0; errors = 0; done_cnt = 0; abort_cnt = 0;
    test_reset;
    test_single;
    test_back_to_back;
    test_stall;
    test_random;
    test_addr_err;
    test_abort;
    test_reset_mid;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule
